// File: rtl/regfile_arb_pkg.sv
// Shared constants and state encoding for the register-file read arbiter.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 16;

    // IDLE: no grant outstanding; ISSUE: a grant is driving the mux;
    // LOCKED: one requester owns the mux for back-to-back reads.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/regfile_read_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: returns the first set bit of eligible
// found by searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    localparam int SUM_W = PTR_W + 1;

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [SUM_W-1:0]     offset;
    logic [SUM_W-1:0]     sum;

    // Rotate so that bit 0 of rotated corresponds to requester rr_ptr+1.
    assign doubled = {eligible, eligible} >> ({1'b0, rr_ptr} + SUM_W'(1));
    assign rotated = doubled[NUM_REQ-1:0];

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        offset = '0;
        any    = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = SUM_W'(j);
                any    = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr} + SUM_W'(1) + offset;
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end
        winner = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 16:1 register-file read mux among NUM_REQ
// requesters. Grant and mux select are registered; the mux output is captured
// one cycle later and tagged with a one-hot rd_valid.
// Optional feature: define REGFILE_ARB_LOCK_EN to add the lock input and the
// LOCKED state for atomic back-to-back reads by a single requester.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    output logic [ADDR_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]         mux_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_reg, state_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [ADDR_W-1:0]   mux_sel_reg, mux_sel_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [DATA_W-1:0]   rd_data_reg;
    logic [NUM_REQ-1:0]  rd_valid_reg;

    logic [NUM_REQ-1:0]  eligible;
    logic [PTR_W-1:0]    pick_winner;
    logic                pick_any;
    logic [ADDR_W-1:0]   req_addr [NUM_REQ];

    // Unpack the flat address bus into one index per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign req_addr[gi] = addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Eligibility: last cycle's winner is masked unless it holds the lock.
    always_comb begin
        eligible = req & ~gnt_reg;
`ifdef REGFILE_ARB_LOCK_EN
        if ((state_reg == LOCKED) && lock[rr_ptr_reg] && req[rr_ptr_reg]) begin
            eligible = '0;
            eligible[rr_ptr_reg] = 1'b1;
        end
`endif
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_reg),
        .winner   (pick_winner),
        .any      (pick_any)
    );

    // Next grant, mux select, pointer and state from the picked winner.
    always_comb begin
        gnt_next     = '0;
        mux_sel_next = mux_sel_reg;
        rr_ptr_next  = rr_ptr_reg;
        state_next   = IDLE;
        if (pick_any) begin
            gnt_next[pick_winner] = 1'b1;
            mux_sel_next          = req_addr[pick_winner];
            rr_ptr_next           = pick_winner;
            state_next            = ISSUE;
`ifdef REGFILE_ARB_LOCK_EN
            if (lock[pick_winner]) begin
                state_next = LOCKED;
            end
`endif
        end
    end

    // Arbitration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            mux_sel_reg <= '0;
            rr_ptr_reg  <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            mux_sel_reg <= mux_sel_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    // Capture the mux output one cycle after grant and tag its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= '0;
        end else if (gnt_reg != '0) begin
            rd_data_reg  <= mux_data;
            rd_valid_reg <= gnt_reg;
        end else begin
            rd_valid_reg <= '0;
        end
    end

    assign gnt      = gnt_reg;
    assign mux_sel  = mux_sel_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed testbench for regfile_read_arbiter (4 requesters, 16-bit data).
module tb_regfile_read_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] addr;
`ifdef REGFILE_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  mux_sel;
    logic [15:0] mux_data;
    logic [3:0]  gnt;
    logic [15:0] rd_data;
    logic [3:0]  rd_valid;
    logic        busy;

    logic [15:0] regs [16];
    int errors;
    int checks;

    regfile_read_arbiter #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .addr     (addr),
`ifdef REGFILE_ARB_LOCK_EN
        .lock     (lock),
`endif
        .mux_sel  (mux_sel),
        .mux_data (mux_data),
        .gnt      (gnt),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    // Register bank behind the 16:1 mux.
    assign mux_data = regs[mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per completed read.
    always @(negedge clk) begin
        if (!reset && rd_valid != 4'b0)
            $display("read: rd_valid=%b rd_data=%h", rd_valid, rd_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 4'b0;
        addr  = 16'h0;
`ifdef REGFILE_ARB_LOCK_EN
        lock  = 4'b0;
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b0; addr = 16'h0;
        tick(); tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (mux_sel !== 4'h0) begin errors++; $display("FAIL reset_mux_sel got=%h exp=0", mux_sel); end
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0000", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        req = 4'b0001; addr = 16'h0006;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midgrant_gnt got=%b exp=0001", gnt); end
        // Async reset while the grant is outstanding.
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL async_gnt got=%b exp=0000", gnt); end
        checks++; if (mux_sel !== 4'h0) begin errors++; $display("FAIL async_mux_sel got=%h exp=0", mux_sel); end
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL async_rd_valid got=%b exp=0000", rd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy); end
        req = 4'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL post_release_rd_valid1 got=%b exp=0000", rd_valid); end
        tick();
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL post_release_rd_valid2 got=%b exp=0000", rd_valid); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL post_release_gnt got=%b exp=0000", gnt); end
    endtask

    task automatic test_single_read();
        apply_reset();
        req = 4'b0100; addr = 16'h0A00;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        checks++; if (mux_sel !== 4'hA) begin errors++; $display("FAIL single_mux_sel got=%h exp=a", mux_sel); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0000", rd_valid); end
        req = 4'b0;
        tick();
        checks++; if (rd_valid !== 4'b0100) begin errors++; $display("FAIL single_rd_valid got=%b exp=0100", rd_valid); end
        checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL single_rd_data got=%h exp=1234", rd_data); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL single_gnt_clear got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear got=%b exp=0", busy); end
        tick();
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL single_valid_pulse got=%b exp=0000", rd_valid); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt [5];
        logic [3:0] exp_sel [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_sel = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h1};
        apply_reset();
        addr = 16'h7531; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (gnt !== exp_gnt[i]) begin errors++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt[i]); end
            checks++; if (mux_sel !== exp_sel[i]) begin errors++; $display("FAIL contention_mux_sel[%0d] got=%h exp=%h", i, mux_sel, exp_sel[i]); end
            if (i > 0) begin
                checks++; if (rd_valid !== exp_gnt[i-1]) begin errors++; $display("FAIL contention_rd_valid[%0d] got=%b exp=%b", i, rd_valid, exp_gnt[i-1]); end
                checks++; if (rd_data !== regs[exp_sel[i-1]]) begin errors++; $display("FAIL contention_rd_data[%0d] got=%h exp=%h", i, rd_data, regs[exp_sel[i-1]]); end
            end
        end
        req = 4'b0;
        tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL contention_drain_gnt got=%b exp=0000", gnt); end
        checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL contention_drain_valid got=%b exp=0001", rd_valid); end
        checks++; if (rd_data !== regs[1]) begin errors++; $display("FAIL contention_drain_data got=%h exp=%h", rd_data, regs[1]); end
        tick();
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL contention_idle_valid got=%b exp=0000", rd_valid); end
    endtask

    task automatic test_self_mask();
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        addr = 16'h0090; req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_g = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            exp_v = (i % 2 == 1) ? 4'b0010 : 4'b0000;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL selfmask_gnt[%0d] got=%b exp=%b", i, gnt, exp_g); end
            checks++; if (rd_valid !== exp_v) begin errors++; $display("FAIL selfmask_valid[%0d] got=%b exp=%b", i, rd_valid, exp_v); end
            if (exp_v != 4'b0) begin
                checks++; if (rd_data !== regs[9]) begin errors++; $display("FAIL selfmask_data[%0d] got=%h exp=%h", i, rd_data, regs[9]); end
            end
        end
        req = 4'b0;
        tick();
        checks++; if (gnt !== 4'b0 || rd_valid !== 4'b0) begin errors++; $display("FAIL selfmask_idle got gnt=%b rd_valid=%b exp=0000/0000", gnt, rd_valid); end
    endtask

    task automatic test_wrap_fairness();
        addr = 16'h2004; req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_setup_gnt got=%b exp=1000", gnt); end
        req = 4'b0;
        tick();
        req = 4'b1001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_first_gnt got=%b exp=0001", gnt); end
        checks++; if (mux_sel !== 4'h4) begin errors++; $display("FAIL wrap_first_sel got=%h exp=4", mux_sel); end
        // Waiting requester changes its address before its grant.
        addr = 16'hE004; req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_second_gnt got=%b exp=1000", gnt); end
        checks++; if (mux_sel !== 4'hE) begin errors++; $display("FAIL wrap_second_sel got=%h exp=e", mux_sel); end
        checks++; if (rd_valid !== 4'b0001 || rd_data !== regs[4]) begin errors++; $display("FAIL wrap_first_read got=%b/%h exp=0001/%h", rd_valid, rd_data, regs[4]); end
        req = 4'b0;
        tick();
        checks++; if (rd_valid !== 4'b1000 || rd_data !== regs[14]) begin errors++; $display("FAIL wrap_second_read got=%b/%h exp=1000/%h", rd_valid, rd_data, regs[14]); end
    endtask

    task automatic test_drop_before_win();
        addr = 16'h0B00; req = 4'b0100;
        #3;
        req = 4'b0;
        tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL drop_gnt got=%b exp=0000", gnt); end
        tick();
        checks++; if (rd_valid !== 4'b0) begin errors++; $display("FAIL drop_rd_valid got=%b exp=0000", rd_valid); end
    endtask

`ifdef REGFILE_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        addr = 16'h0063; req = 4'b0011; lock = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001 || mux_sel !== 4'h3) begin errors++; $display("FAIL lock_first got=%b/%h exp=0001/3", gnt, mux_sel); end
        addr = 16'h0065;
        tick();
        checks++; if (gnt !== 4'b0001 || mux_sel !== 4'h5) begin errors++; $display("FAIL lock_second got=%b/%h exp=0001/5", gnt, mux_sel); end
        checks++; if (rd_valid !== 4'b0001 || rd_data !== regs[3]) begin errors++; $display("FAIL lock_read1 got=%b/%h exp=0001/%h", rd_valid, rd_data, regs[3]); end
        lock = 4'b0; req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010 || mux_sel !== 4'h6) begin errors++; $display("FAIL lock_release got=%b/%h exp=0010/6", gnt, mux_sel); end
        checks++; if (rd_valid !== 4'b0001 || rd_data !== regs[5]) begin errors++; $display("FAIL lock_read2 got=%b/%h exp=0001/%h", rd_valid, rd_data, regs[5]); end
        req = 4'b0;
        tick();
        checks++; if (rd_valid !== 4'b0010 || rd_data !== regs[6]) begin errors++; $display("FAIL lock_read3 got=%b/%h exp=0010/%h", rd_valid, rd_data, regs[6]); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        for (int k = 0; k < 16; k++) regs[k] = 16'(k * 256 + 17);
        regs[10] = 16'h1234;
        reset = 1'b1;
        req   = 4'b0;
        addr  = 16'h0;
`ifdef REGFILE_ARB_LOCK_EN
        lock  = 4'b0;
`endif
        test_reset();
        test_single_read();
        test_contention();
        test_self_mask();
        test_wrap_fairness();
        test_drop_before_win();
`ifdef REGFILE_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
